// File: rtl/reg_dual_read.sv
// Register file with one write port and two read ports that share a single
// storage access per cycle. A write always wins the cycle; otherwise pending
// reads are served one per cycle, alternating round-robin when both wait.
module reg_dual_read #(
  parameter int w     = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [w-1:0]  wr_data,
  input  logic          rd_req1,
  input  logic [AW-1:0] rd_addr1,
  output logic          rd_gnt1,
  output logic [w-1:0]  rd_data1,
  output logic          rd_valid1,
  input  logic          rd_req2,
  input  logic [AW-1:0] rd_addr2,
  output logic          rd_gnt2,
  output logic [w-1:0]  rd_data2,
  output logic          rd_valid2
);

  localparam int NP = 2;

  // Port index 0 is read port 1, index 1 is read port 2.
  logic [NP-1:0]           w_req;
  logic [NP-1:0]           w_gnt;
  logic [NP-1:0][AW-1:0]   w_addr;
  logic [NP-1:0][w-1:0]    r_data;
  logic [NP-1:0]           r_valid;
  logic [DEPTH-1:0][w-1:0] r_mem;
  // 0: port 1 was granted last, 1: port 2 was granted last.
  logic                    r_last;

  assign w_req  = {rd_req2, rd_req1};
  assign w_addr = {rd_addr2, rd_addr1};

  // Arbitration: write owns the cycle; a lone requester wins; on a tie the
  // port that was not granted last goes. Nothing is granted during reset.
  always_comb begin
    w_gnt = '0;
    if (!rst && !wr_en) begin
      if (w_req[0] && w_req[1]) begin
        if (r_last) w_gnt[0] = 1'b1;
        else        w_gnt[1] = 1'b1;
      end else begin
        w_gnt = w_req;
      end
    end
  end

  assign rd_gnt1 = w_gnt[0];
  assign rd_gnt2 = w_gnt[1];

  // Storage: the write port is served whenever wr_en is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_mem          <= '0;
    else if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  // Round-robin history: only read grants move it, writes leave it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_last <= 1'b1;
    else if (w_gnt[0]) r_last <= 1'b0;
    else if (w_gnt[1]) r_last <= 1'b1;
  end

  // Per-port read register: capture on grant, hold otherwise, pulse valid.
  for (genvar p = 0; p < NP; p++) begin : g_port
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_data[p]  <= '0;
        r_valid[p] <= 1'b0;
      end else begin
        r_valid[p] <= w_gnt[p];
        if (w_gnt[p]) r_data[p] <= r_mem[w_addr[p]];
      end
    end
  end

  assign rd_data1  = r_data[0];
  assign rd_valid1 = r_valid[0];
  assign rd_data2  = r_data[1];
  assign rd_valid2 = r_valid[1];

endmodule
